// File: rtl/vga_pkg.sv
// Shared VGA widths, colours and plot arbiter state encoding.
package vga_pkg;

  localparam int X_W   = 9;
  localparam int Y_W   = 8;
  localparam int COL_W = 3;

  localparam logic [COL_W-1:0] BLACK = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/vga_plot_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr_i,
// wrapping modulo N. Purely combinational.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [2:0]   ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [2:0]   idx_o,
  output logic         any_o
);

  logic [N-1:0] rot;
  int           sel;
  int           sum;

  always_comb begin
    rot   = N'({req_i, req_i} >> ptr_i);
    sel   = 0;
    sum   = 0;
    any_o = 1'b0;
    // Scan downwards so the lowest rotated offset wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any_o = 1'b1;
        sel   = k;
      end
    end
    sum = int'(ptr_i) + sel;
    if (sum >= N) sum = sum - N;
    idx_o = 3'(sum);
    gnt_o = any_o ? (N'(1) << sum) : '0;
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin VGA pixel port arbiter for sprite engines.
// Optional hung-engine watchdog: define PLOT_ARB_WATCHDOG_EN.
module vga_plot_arbiter
  import vga_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_plot,
  input  logic [9*NUM_REQ-1:0]   req_x,
  input  logic [8*NUM_REQ-1:0]   req_y,
  input  logic [3*NUM_REQ-1:0]   req_colour,
  output logic [NUM_REQ-1:0]     grant,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [COL_W-1:0]       colour,
  output logic                   plot,
  output logic [2:0]             owner,
  output logic                   busy,
  output logic                   revoked
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 ||
      MAX_BURST < 1 || MAX_BURST > 255 ||
      IDLE_TIMEOUT < 2 || IDLE_TIMEOUT > 255) begin : g_bad_param
    $error("vga_plot_arbiter: parameter out of range");
  end

  arb_state_e           state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [2:0]           owner_q;
  logic                 busy_q;
  logic [7:0]           cnt_q;
  logic [7:0]           cnt_d;
  logic [2:0]           ptr_q;
  logic [2:0]           ptr_d;
  logic [X_W-1:0]       x_q;
  logic [Y_W-1:0]       y_q;
  logic [COL_W-1:0]     col_q;
  logic                 plot_q;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [2:0]           pick_idx;
  logic                 pick_any;

  logic [IW-1:0]        oi;
  logic [X_W-1:0]       own_x;
  logic [Y_W-1:0]       own_y;
  logic [COL_W-1:0]     own_col;
  logic                 in_grant;
  logic                 accept;
  logic                 last;
  logic                 wd_hit;
  logic                 burst_end;

  rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign oi      = owner_q[IW-1:0];
  assign own_x   = req_x[X_W*int'(oi) +: X_W];
  assign own_y   = req_y[Y_W*int'(oi) +: Y_W];
  assign own_col = req_colour[COL_W*int'(oi) +: COL_W];

  assign in_grant = (state_q == ST_GRANT);
  assign accept   = in_grant && grant_q[oi] && req_plot[oi];
  assign last     = accept && (cnt_q == 8'(MAX_BURST - 1));
  assign cnt_d    = cnt_q + 8'd1;
  assign ptr_d    = (int'(oi) == NUM_REQ - 1) ? 3'd0
                                              : owner_q + 3'd1;

`ifdef PLOT_ARB_WATCHDOG_EN
  logic [7:0] wd_q;
  logic       revoked_q;

  assign wd_hit  = in_grant && !accept &&
                   (wd_q == 8'(IDLE_TIMEOUT - 1));
  assign revoked = revoked_q;
`else
  assign wd_hit  = 1'b0;
  assign revoked = 1'b0;
`endif

  assign burst_end = in_grant && (!req[oi] || last || wd_hit);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= 3'd0;
      busy_q  <= 1'b0;
      cnt_q   <= 8'd0;
      ptr_q   <= 3'd0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= BLACK;
      plot_q  <= 1'b0;
`ifdef PLOT_ARB_WATCHDOG_EN
      wd_q      <= 8'd0;
      revoked_q <= 1'b0;
`endif
    end else begin
      // Pixel path: only the owner's accepted pixel reaches the port.
      plot_q <= accept;
      if (accept) begin
        x_q   <= own_x;
        y_q   <= own_y;
        col_q <= own_col;
      end
`ifdef PLOT_ARB_WATCHDOG_EN
      revoked_q <= 1'b0;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            state_q <= ST_GRANT;
            grant_q <= pick_gnt;
            owner_q <= pick_idx;
            busy_q  <= 1'b1;
            cnt_q   <= 8'd0;
`ifdef PLOT_ARB_WATCHDOG_EN
            wd_q    <= 8'd0;
`endif
          end
        end
        ST_GRANT: begin
          if (burst_end) begin
            state_q <= ST_GAP;
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= ptr_d;
`ifdef PLOT_ARB_WATCHDOG_EN
            revoked_q <= wd_hit;
`endif
          end else begin
            if (accept) cnt_q <= cnt_d;
`ifdef PLOT_ARB_WATCHDOG_EN
            wd_q <= accept ? 8'd0 : wd_q + 8'd1;
`endif
          end
        end
        ST_GAP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant  = grant_q;
  assign owner  = owner_q;
  assign busy   = busy_q;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = col_q;
  assign plot   = plot_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Randomised engines against a burst-level arbitration model.
// Honours PLOT_ARB_WATCHDOG_EN like the design.
module tb_vga_plot_arbiter;

  localparam int N  = 4;
  localparam int MB = 16;
  localparam int TO = 64;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   req_plot = '0;
  logic [9*N-1:0] req_x = '0;
  logic [8*N-1:0] req_y = '0;
  logic [3*N-1:0] req_colour = '0;
  logic [N-1:0]   grant;
  logic [8:0]     x;
  logic [7:0]     y;
  logic [2:0]     colour;
  logic           plot;
  logic [2:0]     owner;
  logic           busy;
  logic           revoked;

  vga_plot_arbiter #(
    .NUM_REQ      (N),
    .MAX_BURST    (MB),
    .IDLE_TIMEOUT (TO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_plot   (req_plot),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_colour (req_colour),
    .grant      (grant),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .owner      (owner),
    .busy       (busy),
    .revoked    (revoked)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Engine state: pixels drawn / pixels wanted, stall forces no plotting.
  int pos [N];
  int len [N];
  bit stall [N];
  int pprob = 100;
  bit drop_en = 1'b0;

  // Model: current holder (-1 none), pixels in burst, idle cycles,
  // pending turnaround cycle and rotation pointer.
  int holder = -1;
  int taken = 0;
  int idle = 0;
  bit cool = 1'b0;
  int ptr = 0;
  logic [8:0] lx = '0;
  logic [7:0] ly = '0;
  logic [2:0] lc = '0;
  logic [N-1:0] e_grant = '0;
  logic [2:0] e_owner = '0;
  bit e_busy = 1'b0;
  bit e_plot = 1'b0;
  bit e_rev = 1'b0;
  int nplot = 0;
  int nrev = 0;

  function automatic logic [8:0] px(int i, int p);
    return 9'(125 + p % 4 + 40 * i);
  endfunction

  function automatic logic [7:0] py(int i, int p);
    return 8'(165 + p / 4 + 12 * i);
  endfunction

  function automatic logic [2:0] pc(int i, int p);
    return 3'((p + i) % 7 + 1);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(bit rst, bit drop_any);
    bit dropv [N];
    bit acc;
    bit done;
    bit wd;
    @(negedge clock);
    reset = rst;
    for (int i = 0; i < N; i++) begin
      dropv[i] = drop_any && holder == i && pos[i] > 0 &&
                 $urandom_range(15) == 0;
      req[i] = pos[i] < len[i] && !dropv[i];
      req_plot[i] = pos[i] < len[i] && !stall[i] &&
                    $urandom_range(99) < pprob;
      req_x[9*i +: 9] = px(i, pos[i]);
      req_y[8*i +: 8] = py(i, pos[i]);
      req_colour[3*i +: 3] = pc(i, pos[i]);
    end
    e_plot = 1'b0;
    e_rev = 1'b0;
    if (rst) begin
      holder = -1; taken = 0; idle = 0; cool = 1'b0; ptr = 0;
      lx = '0; ly = '0; lc = '0; e_owner = '0;
      for (int i = 0; i < N; i++) begin
        pos[i] = 0; len[i] = 0; stall[i] = 1'b0;
      end
    end else if (holder >= 0) begin
      acc = req_plot[holder];
      if (acc) begin
        e_plot = 1'b1;
        lx = px(holder, pos[holder]);
        ly = py(holder, pos[holder]);
        lc = pc(holder, pos[holder]);
        pos[holder]++;
        idle = 0;
      end else begin
        idle++;
      end
      done = !req[holder] || (acc && taken + 1 == MB);
`ifdef PLOT_ARB_WATCHDOG_EN
      wd = !acc && idle == TO;
`else
      wd = 1'b0;
`endif
      if (wd) begin
        done = 1'b1;
        e_rev = 1'b1;
      end
      if (dropv[holder]) len[holder] = pos[holder];
      if (done) begin
        ptr = (holder + 1) % N;
        holder = -1;
        cool = 1'b1;
      end else begin
        taken += int'(acc);
      end
    end else if (cool) begin
      cool = 1'b0;
    end else begin
      for (int j = 0; j < N; j++) begin
        if (holder < 0 && req[(ptr + j) % N]) begin
          holder = (ptr + j) % N;
          taken = 0;
          idle = 0;
          e_owner = 3'(holder);
        end
      end
    end
    e_busy = holder >= 0;
    e_grant = e_busy ? N'(1 << holder) : '0;
    @(posedge clock);
    #1;
    chk("grant", 32'(grant), 32'(e_grant));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("plot", 32'(plot), 32'(e_plot));
    chk("revoked", 32'(revoked), 32'(e_rev));
    chk("pixel", {9'd0, x, y, 1'b0, colour}, {9'd0, lx, ly, 1'b0, lc});
    if (e_busy) chk("owner", 32'(owner), 32'(e_owner));
    if (plot === 1'b1) nplot++;
    if (revoked === 1'b1) nrev++;
  endtask

  function automatic bit pending();
    bit p = holder >= 0 || cool;
    for (int i = 0; i < N; i++) if (pos[i] < len[i]) p = 1'b1;
    return p;
  endfunction

  task automatic run(int maxc);
    int c = 0;
    while (pending()) begin
      if (c >= maxc) begin
        checks++;
        failures++;
        $error("FAIL timeout got=%0d exp<%0d", c, maxc);
        break;
      end
      step(1'b0, drop_en);
      c++;
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pos[i] = 0; len[i] = 0; stall[i] = 1'b0;
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Single requester, 16 back-to-back pixels.
    nplot = 0;
    len[1] = 16;
    run(100);
    chk("single_plots", 32'(nplot), 32'd16);

    // Contention from reset pointer: 0 then 2.
    step(1'b1, 1'b0);
    len[0] = 16;
    len[2] = 16;
    run(200);

    // Longer than MAX_BURST: bursts 16,16,4,4 alternating.
    step(1'b1, 1'b0);
    len[0] = 20;
    len[1] = 20;
    run(200);

    // Early release after 5 pixels, then pointer wraps to 0.
    nplot = 0;
    len[3] = 5;
    run(100);
    chk("early_plots", 32'(nplot), 32'd5);
    len[0] = 2;
    len[3] = 2;
    run(100);

    // Reset in the middle of a burst with a non-zero pointer.
    len[2] = 3;
    run(100);
    len[1] = 16;
    for (int c = 0; c < 100 && pos[1] < 7; c++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    step(1'b0, 1'b0);
    len[1] = 4;
    len[3] = 4;
    run(100);

    // Hung engine 2 with engine 3 waiting.
    nrev = 0;
    len[2] = 6;
    stall[2] = 1'b1;
    for (int c = 0; c < 50 && holder != 2; c++) step(1'b0, 1'b0);
    len[3] = 4;
    for (int c = 0; c < 80; c++) step(1'b0, 1'b0);
`ifdef PLOT_ARB_WATCHDOG_EN
    chk("wd_revokes", 32'(nrev), 32'd1);
`else
    chk("wd_revokes", 32'(nrev), 32'd0);
`endif
    stall[2] = 1'b0;
    run(300);

    // Random lengths, plot gaps and early drops.
    pprob = 60;
    drop_en = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) len[i] = pos[i] + $urandom_range(40);
      run(3000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
